// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline definitions for the 5-stage IF/ID/EX/MEM/WB pipeline:
//   - opcode constants for the supported instructions (R-type, lw, sw, beqz)
//   - EX-stage operand forwarding select codes
//   - hazard controller FSM state enum
//   - helper telling whether an ID opcode reads its rt field
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQZ  = 6'b000100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    // lw and beqz only read rs; R-type and sw also read rt
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// EX-stage forwarding comparators. For each EX source register it selects
// the youngest in-flight producer: MEM result first, then WB result, else
// the register file. Register 0 is never forwarded.
// Ports:
//   ex_rs, ex_rt           in  source registers of the instruction in EX
//   mem_rd, mem_reg_write  in  destination / write enable held in MEM
//   wb_rd, wb_reg_write    in  destination / write enable held in WB
//   fwd_a, fwd_b           out operand selects (FWD_RF / FWD_MEM / FWD_WB)
// ---------------------------------------------------------------------------
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // MEM holds the more recent value, so it wins over WB when both match
    function automatic logic [1:0] pick_src(input logic [4:0] src,
                                            input logic [4:0] m_rd,
                                            input logic       m_we,
                                            input logic [4:0] w_rd,
                                            input logic       w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == src))
            return FWD_MEM;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = pick_src(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    assign fwd_b = pick_src(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and stall controller for the 5-stage pipeline. Detects load-use
// hazards between ID and EX, data-memory waits in MEM and taken branches in
// ID, and from these drives pipeline register enables, the IF/ID flush, the
// ID/EX bubble and the EX forwarding selects. A saturating counter records
// every cycle in which the PC is held.
//
// Build option: macro HAZARD_FWD_EN
//   defined   - forwarding from MEM/WB active; only a load in EX stalls ID
//   undefined - no forwarding (selects stay 00); ID stalls on any RAW
//               against a writing instruction in EX or MEM
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   id_opcode, id_rs, id_rt         instruction in ID
//   beq_taken                       ID resolved a taken beqz
//   ex_rd, ex_rs, ex_rt             EX registers
//   ex_mem_read, ex_reg_write       EX control bits
//   mem_rd, mem_reg_write           MEM destination / write enable
//   wb_rd, wb_reg_write             WB destination / write enable
//   dmem_req, dmem_ready            data-memory handshake in MEM
//   pc_en, if_id_en, id_ex_en, ex_mem_en   pipeline register enables
//   if_id_flush, id_ex_bubble       NOP injection controls
//   fwd_a, fwd_b                    EX operand selects
//   stall_cnt                       saturating count of PC-held cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             beq_taken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_t  state, next_state;
    logic       id_rt_used;
    logic       ex_hits;
    logic       lu;
    logic       mw;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign id_rt_used = uses_rt(id_opcode);
    assign ex_hits    = (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs) || (id_rt_used && (ex_rd == id_rt)));
    assign mw         = dmem_req && !dmem_ready;

`ifdef HAZARD_FWD_EN
    logic unused_sink;

    // Only a load in EX cannot be covered by forwarding
    assign lu          = ex_mem_read && ex_hits;
    assign fwd_a       = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b       = reset ? FWD_RF : fwd_b_raw;
    assign unused_sink = ex_reg_write;
`else
    logic mem_hits;
    logic unused_sink;

    // Without forwarding, ID must wait until the producer reaches WB;
    // the regfile is write-first so a WB producer needs no stall
    assign mem_hits    = (mem_rd != 5'd0) &&
                         ((mem_rd == id_rs) || (id_rt_used && (mem_rd == id_rt)));
    assign lu          = (ex_reg_write && ex_hits) || (mem_reg_write && mem_hits);
    assign fwd_a       = FWD_RF;
    assign fwd_b       = FWD_RF;
    assign unused_sink = ^{ex_mem_read, fwd_a_raw, fwd_b_raw};
`endif

    // State register; reset drops any pending stall immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= next_state;
    end

    // Next state plus pipeline controls. Controls depend only on the current
    // inputs so a stall takes effect in the same cycle it is detected; a
    // memory wait outranks load-use, which outranks a taken branch (the
    // branch re-resolves once ID is released).
    always_comb begin
        next_state   = state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        unique case (state)
            RUN: begin
                if (mw)
                    next_state = MEM_WAIT;
                else if (lu)
                    next_state = LU_STALL;
            end
            LU_STALL: next_state = mw ? MEM_WAIT : RUN;
            MEM_WAIT: begin
                if (!mw)
                    next_state = RUN;
            end
            default:  next_state = RUN;
        endcase

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mw) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
        end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (beq_taken) begin
            if_id_flush  = 1'b1;
        end
    end

    // Stall-cycle counter: counts every cycle the PC is held, sticks at max
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline (IF/ID/EX/MEM/WB) executing R-type, lw, sw and beqz. It watches the instruction decoded in ID, the destinations held in EX/MEM/WB and the data-memory handshake. From these it drives the pipeline-register enables, bubble and flush controls and the EX-stage forwarding selects. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_opcode  in  6  opcode of instruction in ID
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- beq_taken  in  1  ID has resolved a taken beqz
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read, ex_reg_write  in  1 each  EX-stage control bits
- ex_rs, ex_rt  in  5 each  source registers of instruction in EX
- mem_rd  in  5  destination register in MEM
- mem_reg_write  in  1  MEM-stage control bit
- wb_rd  in  5  destination register in WB
- wb_reg_write  in  1  WB-stage control bit
- dmem_req  in  1  MEM stage is issuing a lw/sw access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline register load enables
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_bubble  out  1  load a NOP (all control bits 0) into ID/EX
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- stall_cnt  out  CNT_W  total stalled cycles since reset, saturating

## Operation
- Register 0 never creates a hazard and is never forwarded.
- id_uses_rt is 1 only for opcodes 000000 (R-type) and 101011 (sw). lw and beqz read rs only.
- Load-use hazard (lu): ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Memory wait (mw): dmem_req & ~dmem_ready.
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
  - RUN → MEM_WAIT on mw.
  - RUN → LU_STALL on lu & ~mw.
  - LU_STALL → RUN unconditionally after one cycle, or → MEM_WAIT if mw.
  - MEM_WAIT → RUN in the cycle after dmem_ready is sampled high.
- Output rules, in priority order:
  - mw: all four enables 0, no bubble, no flush. The whole pipeline freezes.
  - lu: pc_en=0, if_id_en=0, id_ex_bubble=1. EX and MEM advance.
  - beq_taken: if_id_flush=1, everything else advances.
  - Otherwise all enables are 1 and there is no flush or bubble.
- A taken branch coinciding with lu or mw is ignored. The branch re-resolves after the stall because ID is held.
- Forwarding for fwd_a (fwd_b is the same with ex_rt):
  - 01 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs.
  - Else 10 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rs.
  - Else 00. MEM has priority over WB.
- stall_cnt increments each cycle pc_en=0 and holds at all-ones.

## Timing
- All hazard, enable and forward outputs are combinational from inputs in the same cycle. Only the FSM state and stall_cnt are registered.
- While reset is high:
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
  - id_ex_bubble=1, if_id_flush=0, fwd_a=fwd_b=00, stall_cnt=0.
- Load-use costs exactly 1 cycle. The dependent instruction sees fwd=10 from WB in its EX cycle.
- A memory wait of N cycles with ready low adds N stall cycles. The ready cycle itself advances.
- Reset asserted mid-stall forces RUN immediately and clears the counter. No pending stall survives reset.

## Configuration
- HAZARD_FWD_EN defined: behaviour as above.
- HAZARD_FWD_EN undefined:
  - fwd_a=fwd_b=00 constantly.
  - The lu condition is widened to any RAW between ID sources and EX (ex_reg_write) or MEM (mem_reg_write) destinations.
  - The stall repeats each cycle until the producer reaches WB. The regfile is write-first, so WB needs no stall.

## Structure
- The shared pipeline package holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQZ=000100
  - the fwd select constants FWD_RF/FWD_MEM/FWD_WB
  - the FSM state enum
- One sub-module, fwd_unit, is natural. It holds the two forwarding comparators; the FSM and counter stay at top level.

## Test plan
- lw r2 in EX, add r3,r2,r4 in ID -> one cycle of pc_en=0 and id_ex_bubble=1, then fwd_a=10 for the add in EX; stall_cnt=1.
- lw r2 in EX, beqz r5 in ID with beq_taken=1 -> no stall and if_id_flush=1; with beqz r2 -> stall first, flush suppressed that cycle.
- dmem_req=1 with dmem_ready low for 3 cycles, then high -> all enables 0 for 3 cycles, resume on cycle 4; stall_cnt=3.
- mem_rd=wb_rd=r7 both writing, ex_rs=r7 -> fwd_a=01; ex_rd=0 load with id_rs=0 -> no stall.
- Reset pulsed during MEM_WAIT -> outputs take reset values immediately; after release the FSM is in RUN and stall_cnt=0.
- Without HAZARD_FWD_EN: add r1 in EX, sub r4,r1,r1 in ID -> 2 stall cycles, fwd stays 00.
